// File: rtl/montgomery_host_sequencer.sv
// montgomery_host_sequencer: loads operands into a montgomery_wrapper, issues the exp/mult command list, captures the result; SEQ_TIMEOUT_EN adds a per-wait watchdog
module montgomery_host_sequencer #(
  parameter int WORD_LEN = 512
`ifdef SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1048576
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_wr_en,
  input  logic [2:0]          op_wr_idx,
  input  logic [WORD_LEN-1:0] op_wr_data,
  input  logic                job_start,
  input  logic                job_mode,
  output logic                busy,
  output logic                job_done,
  output logic                job_err,
  output logic [WORD_LEN-1:0] result,
  output logic [31:0]         port1_din,
  output logic                port1_valid,
  input  logic                port1_read,
  input  logic                port2_valid,
  output logic                port2_read,
  output logic [WORD_LEN-1:0] bram_din1,
  output logic                bram_din_valid,
  input  logic [WORD_LEN-1:0] bram_dout1,
  input  logic                bram_dout1_valid,
  output logic                bram_dout_read
);
  localparam logic [2:0] IDLE = 3'd0, CMD = 3'd1, BRAM_WR = 3'd2, WAIT_DONE = 3'd3, DRAIN = 3'd4, RES_WAIT = 3'd5, FINISH = 3'd6;
  logic [2:0] state, state_n, step;
  logic mode, res_got, cmp_got, timeout, is_op, is_last, p1_fire;
  logic [3:0] cmd;
  logic [WORD_LEN-1:0] slot [5];
  logic [WORD_LEN-1:0] bram_hold;
  // Operand commands come first in both lists and equal the step; later commands are step+2 (exp 7,8 / mult 5,6)
  assign is_op = step < (mode ? 3'd3 : 3'd5);
  assign is_last = step == (mode ? 3'd4 : 3'd6);
  assign cmd = is_op ? {1'b0, step} : {1'b0, step} + 4'd2;
  assign port1_valid = state == CMD && !timeout;
  assign port1_din = port1_valid ? {28'd0, cmd} : 32'd0;
  assign p1_fire = port1_valid && port1_read;
  assign port2_read = !timeout && port2_valid && (state == WAIT_DONE || (state == RES_WAIT && !cmp_got));
  assign bram_dout_read = !timeout && state == RES_WAIT && bram_dout1_valid && !res_got;
  assign bram_din_valid = state == BRAM_WR;
  assign bram_din1 = bram_din_valid ? slot[step] : bram_hold;
  assign busy = state != IDLE && state != FINISH;
  assign job_done = state == FINISH;
`ifdef SEQ_TIMEOUT_EN
  logic [31:0] wd;
  logic counting;
  assign counting = state == CMD || state == WAIT_DONE || state == DRAIN || state == RES_WAIT;
  assign timeout = counting && wd == 32'(TIMEOUT_CYCLES - 1);
  // Watchdog restarts on every state change and runs only while waiting on the wrapper
  always_ff @(posedge clk)
    if (reset || state_n != state) wd <= '0;
    else if (counting) wd <= wd + 32'd1;
`else
  assign timeout = 1'b0;
`endif
  // Next-state selection; a watchdog expiry overrides every wait
  always_comb begin
    state_n = state;
    if (timeout) state_n = FINISH;
    else
      unique case (state)
        IDLE:      state_n = job_start ? CMD : IDLE;
        CMD:       state_n = !p1_fire ? CMD : is_op ? BRAM_WR : is_last ? RES_WAIT : WAIT_DONE;
        BRAM_WR:   state_n = WAIT_DONE;
        WAIT_DONE: state_n = port2_valid ? DRAIN : WAIT_DONE;
        DRAIN:     state_n = port2_valid ? DRAIN : CMD;
        RES_WAIT:  state_n = res_got && cmp_got && !port2_valid ? FINISH : RES_WAIT;
        FINISH:    state_n = IDLE;
        default:   state_n = IDLE;
      endcase
  end
  // Sequencer state, job latches, result capture and held BRAM word
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      step <= '0;
      mode <= 1'b0;
      res_got <= 1'b0;
      cmp_got <= 1'b0;
      job_err <= 1'b0;
      result <= '0;
      bram_hold <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && job_start) begin
        step <= '0;
        mode <= job_mode;
        job_err <= 1'b0;
      end
      if (state == DRAIN && !port2_valid) step <= step + 3'd1;
      if (p1_fire) begin
        res_got <= 1'b0;
        cmp_got <= 1'b0;
      end
      if (bram_dout_read) begin
        result <= bram_dout1;
        res_got <= 1'b1;
      end
      if (state == RES_WAIT && port2_read) cmp_got <= 1'b1;
      if (bram_din_valid) bram_hold <= slot[step];
      if (timeout) job_err <= 1'b1;
    end
  // Operand slots accept writes in any state; indices 5-7 are dropped
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < 5; i++) slot[i] <= '0;
    else if (op_wr_en && op_wr_idx < 3'd5) slot[op_wr_idx] <= op_wr_data;
endmodule

// File: tb/tb_montgomery_host_sequencer.sv
// tb_montgomery_host_sequencer: directed jobs against a configurable wrapper responder, checked against a command-list/slot model
module tb_montgomery_host_sequencer;
  localparam int W = 512;
  logic clk = 1'b0, reset = 1'b1;
  logic op_wr_en = 1'b0, job_start = 1'b0, job_mode = 1'b0;
  logic [2:0] op_wr_idx = '0;
  logic [W-1:0] op_wr_data = '0;
  logic busy, job_done, job_err, port1_valid, port2_read, bram_din_valid, bram_dout_read;
  logic [W-1:0] result, bram_din1;
  logic [31:0] port1_din;
  logic port1_read = 1'b0, port2_valid = 1'b0, bram_dout1_valid = 1'b0;
  logic [W-1:0] bram_dout1 = '0;

  always #5 clk = ~clk;

  montgomery_host_sequencer #(.WORD_LEN(W)
`ifdef SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .reset(reset), .op_wr_en(op_wr_en), .op_wr_idx(op_wr_idx), .op_wr_data(op_wr_data),
    .job_start(job_start), .job_mode(job_mode), .busy(busy), .job_done(job_done), .job_err(job_err),
    .result(result), .port1_din(port1_din), .port1_valid(port1_valid), .port1_read(port1_read),
    .port2_valid(port2_valid), .port2_read(port2_read), .bram_din1(bram_din1), .bram_din_valid(bram_din_valid),
    .bram_dout1(bram_dout1), .bram_dout1_valid(bram_dout1_valid), .bram_dout_read(bram_dout_read)
  );

  int n_cmp = 0, n_bad = 0;
  task automatic chki(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model state and responder configuration
  logic [W-1:0] slot_model [5];
  logic [W-1:0] res_val = '0;
  int p1_delay = 0, p2_delay = 0, p2_hold = 1, res_delay = 0;
  bit p2_never = 0;
  // responder internals and handshakes observed by the monitor
  int p1_cnt = 0, p2_wait = 0, p2_held = 0, res_wait = 0, cmd_s = 0, cyc = 0, p2r_since = 0;
  bit p2_pending = 0, p2_acked = 0, res_pending = 0;
  bit p1_fire_s = 0, p2r_s = 0, bdr_s = 0, prev_hold = 0, prev_done = 0, prev_dv = 0;
  logic [31:0] prev_din = '0;
  int got_cmd[$], got_cyc[$];
  logic [W-1:0] got_op[$];
  int p2r_cnt = 0, bdr_cnt = 0, done_cnt = 0;

  // responder drives wrapper inputs at negedge, then the monitor samples the settled cycle
  always @(negedge clk) begin
    if (reset) begin
      port1_read = 0; port2_valid = 0; bram_dout1_valid = 0; bram_dout1 = '0;
      p1_cnt = 0; p2_pending = 0; res_pending = 0;
    end else begin
      if (p1_fire_s) begin
        p1_cnt = 0;
        p2_pending = !p2_never;
        p2_wait = p2_delay;
        if (cmd_s == 6 || cmd_s == 8) begin res_pending = 1; res_wait = res_delay; end
      end
      if (port2_valid) begin
        if (p2r_s) p2_acked = 1;
        p2_held++;
        if (p2_acked && p2_held >= p2_hold) port2_valid = 0;
      end else if (p2_pending) begin
        if (p2_wait == 0) begin port2_valid = 1; p2_pending = 0; p2_held = 0; p2_acked = 0; end
        else p2_wait--;
      end
      if (bram_dout1_valid) begin
        if (bdr_s) begin bram_dout1_valid = 0; bram_dout1 = '0; end
      end else if (res_pending) begin
        if (res_wait == 0) begin bram_dout1_valid = 1; bram_dout1 = res_val; res_pending = 0; end
        else res_wait--;
      end
      port1_read = port1_valid && p1_cnt >= p1_delay;
      if (port1_valid) p1_cnt++;
    end
    #1;
    if (reset) begin
      p1_fire_s = 0; p2r_s = 0; bdr_s = 0; prev_hold = 0; prev_done = 0; prev_dv = 0;
    end else begin
      cyc++;
      if (prev_hold) begin
        chki("p1_valid_stable", int'(port1_valid), 1);
        chki("p1_din_stable", int'(port1_din), int'(prev_din));
      end
      prev_hold = port1_valid && !port1_read;
      prev_din = port1_din;
      p1_fire_s = port1_valid && port1_read;
      cmd_s = int'(port1_din);
      if (p1_fire_s) begin
        chki("p2_read_per_cmd", p2r_since, got_cmd.size() == 0 ? 0 : 1);
        p2r_since = 0;
        got_cmd.push_back(cmd_s);
        got_cyc.push_back(cyc);
      end
      if (bram_din_valid) begin
        chki("din_valid_single", int'(prev_dv), 0);
        got_op.push_back(bram_din1);
      end
      prev_dv = bram_din_valid;
      p2r_s = port2_read;
      if (port2_read) begin
        p2r_cnt++; p2r_since++;
        chki("p2_read_with_valid", int'(port2_valid), 1);
      end
      bdr_s = bram_dout_read;
      if (bram_dout_read) begin
        bdr_cnt++;
        chki("dout_read_with_valid", int'(bram_dout1_valid), 1);
      end
      if (job_done) begin
        done_cnt++;
        chki("done_single", int'(prev_done), 0);
        chki("busy_low_at_done", int'(busy), 0);
`ifndef SEQ_TIMEOUT_EN
        chki("job_err_low", int'(job_err), 0);
`endif
      end
      prev_done = job_done;
    end
  end

  task automatic write_op(input int idx, input logic [W-1:0] v);
    @(negedge clk);
    op_wr_en = 1; op_wr_idx = idx[2:0]; op_wr_data = v;
    if (idx < 5) slot_model[idx] = v;
    @(negedge clk);
    op_wr_en = 0;
  endtask

  task automatic start_job(input bit m);
    got_cmd.delete(); got_cyc.delete(); got_op.delete();
    p2r_cnt = 0; bdr_cnt = 0; done_cnt = 0; p2r_since = 0;
    @(negedge clk);
    job_mode = m; job_start = 1;
    @(negedge clk);
    job_start = 0;
    #3;
    chki("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_cmds(input string nm, input int n);
    int k = 0;
    while (got_cmd.size() < n && k < 500) begin @(negedge clk); #3; k++; end
    chki({nm, " cmds_reached"}, int'(got_cmd.size() >= n), 1);
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (done_cnt == 0 && k < 1000) begin @(negedge clk); #3; k++; end
    chki({nm, " done_seen"}, int'(done_cnt != 0), 1);
    repeat (2) @(negedge clk);
    #3;
  endtask

  task automatic check_job(input string nm, input bit m, input logic [W-1:0] er, input bit zw);
    int lst[$];
    int nops = 0;
    if (m) lst = '{0, 1, 2, 5, 6}; else lst = '{0, 1, 2, 3, 4, 7, 8};
    chki({nm, " ncmd"}, got_cmd.size(), lst.size());
    foreach (lst[i]) if (i < got_cmd.size()) chki($sformatf("%s cmd%0d", nm, i), got_cmd[i], lst[i]);
    foreach (lst[i]) if (lst[i] < 5) nops++;
    chki({nm, " nops"}, got_op.size(), nops);
    foreach (lst[i]) if (lst[i] < 5 && i < got_op.size()) chkw($sformatf("%s op%0d", nm, i), got_op[i], slot_model[lst[i]]);
    if (zw) for (int i = 1; i < got_cyc.size() && i < lst.size(); i++)
      chki($sformatf("%s gap%0d", nm, i), got_cyc[i] - got_cyc[i-1], lst[i-1] < 5 ? 4 : 3);
    chki({nm, " p2_reads"}, p2r_cnt, lst.size());
    chki({nm, " dout_reads"}, bdr_cnt, 1);
    chki({nm, " done_pulses"}, done_cnt, 1);
    chkw({nm, " result"}, result, er);
    chki({nm, " busy_after"}, int'(busy), 0);
  endtask

  task automatic chk_zero(input string nm);
    chki({nm, " port1_valid"}, int'(port1_valid), 0);
    chki({nm, " port1_din"}, int'(port1_din), 0);
    chki({nm, " port2_read"}, int'(port2_read), 0);
    chki({nm, " bram_din_valid"}, int'(bram_din_valid), 0);
    chki({nm, " bram_dout_read"}, int'(bram_dout_read), 0);
    chki({nm, " busy"}, int'(busy), 0);
    chki({nm, " job_done"}, int'(job_done), 0);
    chki({nm, " job_err"}, int'(job_err), 0);
    chkw({nm, " bram_din1"}, bram_din1, '0);
    chkw({nm, " result"}, result, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 5; i++) slot_model[i] = '0;
    repeat (3) @(negedge clk);
    #3;
    chk_zero("reset");
    @(negedge clk);
    reset = 0;
    // multiplication, zero-wait responder
    write_op(0, 3); write_op(1, 5); write_op(2, 7); write_op(3, 'h99); write_op(6, 'h77);
    res_val = 'h1234;
    start_job(1);
    wait_done("mult");
    check_job("mult", 1, 'h1234, 1);
    chkw("mult pin op0", got_op[0], 3);
    chkw("mult pin op1", got_op[1], 5);
    chkw("mult pin op2", got_op[2], 7);
    chkw("mult pin result", result, 'h1234);
    // exponentiation, zero-wait responder
    write_op(0, 'hA); write_op(1, 'hB); write_op(2, 'hC); write_op(3, 'hD); write_op(4, 'hE);
    res_val = {16{32'hDEADBEEF}};
    start_job(0);
    wait_done("exp");
    check_job("exp", 0, {16{32'hDEADBEEF}}, 1);
    chkw("exp pin op0", got_op[0], 'hA);
    chkw("exp pin op4", got_op[4], 'hE);
    // backpressure plus an ignored start during step 3
    p1_delay = 5; p2_hold = 4; res_val = 'h55;
    start_job(0);
    wait_cmds("bp", 4);
    @(negedge clk);
    job_mode = 1; job_start = 1;
    @(negedge clk);
    job_start = 0; job_mode = 0;
    #3;
    chki("bp busy_mid", int'(busy), 1);
    wait_done("bp");
    check_job("bp", 0, 'h55, 0);
    p1_delay = 0; p2_hold = 1;
    // result/completion ordering: result late, result early, same cycle
    for (int k = 0; k < 3; k++) begin
      res_delay = k == 0 ? 3 : 0;
      p2_delay = k == 1 ? 3 : 0;
      res_val = W'(256 + k);
      start_job(1);
      wait_done($sformatf("ord%0d", k));
      check_job($sformatf("ord%0d", k), 1, W'(256 + k), 0);
    end
    res_delay = 0;
    // reset while waiting for completion, then a clean job
    p2_delay = 10;
    start_job(1);
    wait_cmds("rst", 2);
    repeat (3) @(negedge clk);
    reset = 1;
    for (int i = 0; i < 5; i++) slot_model[i] = '0;
    repeat (2) @(negedge clk);
    reset = 0;
    #3;
    chk_zero("midreset");
    p2_delay = 0;
    write_op(0, 'h11); write_op(1, 'h22); write_op(2, 'h33);
    res_val = 'hBEEF;
    start_job(1);
    wait_done("clean");
    check_job("clean", 1, 'hBEEF, 1);
`ifdef SEQ_TIMEOUT_EN
    p2_never = 1;
    start_job(1);
    wait_done("timeout");
    chki("timeout job_err", int'(job_err), 1);
    chkw("timeout result_kept", result, 'hBEEF);
    chki("timeout ncmd", got_cmd.size(), 1);
    chki("timeout dout_reads", bdr_cnt, 0);
    p2_never = 0;
    res_val = 'hCAFE;
    start_job(1);
    wait_done("after_to");
    chki("after_to job_err", int'(job_err), 0);
    chkw("after_to result", result, 'hCAFE);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
